hls_deadlock_report_ctrl: RTL
=============================

Name: hls_deadlock_report_ctrl

Overview:
Supervisory controller for the per-process HLS deadlock monitors of the accelerator dataflow region. It sits above the idxN monitors and collects their one-bit block outputs. It confirms a deadlock only when blocking persists for a programmable number of consecutive cycles. It then latches which process blocked first and the full block vector, raises a one-cycle interrupt, and holds the report until software clears it.

Parameters:
N_MON, 4, number of monitor block inputs (≥2)
IDX_W, 2, width of reported index, equals clog2(N_MON)
CNT_W, 16, width of the confirm and duration counters
CONFIRM_CYCLES, 1024, consecutive blocked cycles needed to declare deadlock (2..2^CNT_W-1)

Ports:
clock  in  1  single clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  detection enable; low forces a return to IDLE except from LATCHED
mask  in  N_MON  per-monitor enable; 1 = monitor participates
monitor_block  in  N_MON  registered block outputs of the idx monitors
clear  in  1  single-cycle pulse; acknowledges and clears the report
deadlock_irq  out  1  one-cycle pulse on entry to LATCHED
deadlock_valid  out  1  report held valid while in LATCHED
deadlock_idx  out  IDX_W  index of the first-blocking monitor
deadlock_vec  out  N_MON  masked block vector captured at confirmation
block_cycles  out  CNT_W  saturating count of consecutive blocked cycles in the current or last episode
state_dbg  out  2  encoded state: 0 IDLE, 1 WATCH, 2 LATCHED

Behaviour:
- Reset: state IDLE; all outputs 0; internal counter and candidate index cleared. Reset mid-episode, including in LATCHED, discards everything.
- act = monitor_block & mask; any_act = OR of act. All inputs are sampled on the rising edge of clock.
- IDLE:
  - if enable & any_act: go to WATCH; cnt <= 1; block_cycles <= 1; cand_idx <= lowest set bit of act.
  - otherwise stay; block_cycles holds its last value.
- WATCH:
  - priority 1: clear or !enable -> IDLE, cnt <= 0.
  - priority 2: !any_act -> IDLE, cnt <= 0. block_cycles holds the episode length.
  - priority 3: cnt == CONFIRM_CYCLES-1 -> LATCHED, with deadlock_vec <= act, deadlock_idx <= cand_idx, deadlock_valid <= 1, deadlock_irq <= 1.
  - otherwise: cnt <= cnt+1.
  - In every cycle that stays in or leaves WATCH with any_act set, block_cycles <= sat_inc(block_cycles).
  - cand_idx is fixed at WATCH entry. A different or additional monitor blocking later does not change it.
- Latency: if any_act is sampled high on edges e0 .. e0+CONFIRM_CYCLES-1, then deadlock_valid and deadlock_irq are 1 after edge e0+CONFIRM_CYCLES-1. Any single low sample restarts the count.
- LATCHED:
  - deadlock_irq is 1 only in the first cycle; deadlock_valid, deadlock_idx and deadlock_vec hold.
  - block_cycles keeps saturating-incrementing while any_act is high, and holds when it is low.
  - enable and mask changes are ignored.
  - clear -> IDLE next cycle: deadlock_valid <= 0, deadlock_vec <= 0, deadlock_idx <= 0, block_cycles <= 0.
  - After clear, a still-active block starts a new episode from the following sample.
- Simultaneous events:
  - clear in the same cycle as the confirm condition: clear wins, no irq.
  - clear in IDLE: no effect other than block_cycles <= 0.
  - Several bits set at WATCH entry: the lowest index wins.
- Saturation: block_cycles stops at 2^CNT_W-1 and never wraps. cnt cannot exceed CONFIRM_CYCLES-1.
- state_dbg is a registered copy of the state; 3 is never produced.

Decomposition:
- Shared package hls_deadlock_pkg holds:
  - the state enum constants ST_IDLE=0, ST_WATCH=1, ST_LATCHED=2;
  - the default CNT_W;
  - a sat_inc helper function.
- One natural sub-module: hls_deadlock_prio_enc, a parameterised lowest-set-bit encoder (N_MON in, IDX_W out, plus a found flag), reusable by other monitors.
- The FSM, counters and report registers stay in the top block.

Test Plan:
All scenarios use CONFIRM_CYCLES=8, N_MON=4, mask=4'hF.
1. Reset and persistence: hold reset for 3 cycles, then enable=1 and monitor_block=4'b0100 for 8 cycles -> all outputs 0 during reset; irq pulses exactly once on the 8th edge; valid=1, idx=2, vec=4'b0100, state_dbg=2.
2. Glitch restart: block=4'b0001 for 5 cycles, 0 for 1 cycle, then 1 for 7 cycles -> no irq, state returns to 0 then 1. One more blocked cycle then gives irq with idx=0.
3. First-blocker tracking: block=4'b1000 at e0 and 4'b1010 from e0+2 onward -> at confirmation idx=3, vec=4'b1010.
4. Mask and enable: mask=4'b1110 with block=4'b0001 for 20 cycles -> state stays 0. Then block=4'b0010 with enable dropped at cycle 4 -> IDLE, no irq.
5. Clear vs confirm collision: assert clear on the 8th blocked edge -> no irq and state 0. In LATCHED, clear -> valid=0 and block_cycles=0 the next cycle, and a new episode starts if the block persists.
6. Saturation: CNT_W=4 with the block held for 40 cycles after LATCHED -> block_cycles sticks at 15; valid stays 1 and irq stays 0.

Source files
------------

// File: rtl/hls_deadlock_pkg.sv
// Shared definitions for the HLS deadlock supervisory logic.
// Contents:
//   state_e        - controller state encoding (IDLE / WATCH / LATCHED)
//   DEFAULT_CNT_W  - default width of the confirm and duration counters
//   sat_inc        - saturating increment helper (32-bit carrier, caller truncates)
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WATCH   = 2'd1,
        ST_LATCHED = 2'd2
    } state_e;

    localparam int DEFAULT_CNT_W = 16;

    // Increment value by one but never beyond max_value, so a counter sticks
    // at its ceiling instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        logic [31:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   req_i   [N-1:0]      request vector
//   idx_o   [IDX_W-1:0]  index of the lowest set bit (0 when nothing is set)
//   found_o              1 when any request bit is set
module hls_deadlock_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [IDX_W-1:0] idx_s;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_s = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx_s = req_i[i] ? IDX_W'(i) : idx_s;
        end
    end

    assign idx_o   = idx_s;
    assign found_o = |req_i;

endmodule

// File: rtl/hls_deadlock_report_ctrl.sv
// Supervisory deadlock controller above the per-process HLS block monitors.
// Blocking must persist for CONFIRM_CYCLES consecutive samples before a
// deadlock is declared; the first blocker and the block vector are then
// latched, a one-cycle interrupt is raised and the report holds until clear.
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   enable            detection enable (ignored once a report is latched)
//   mask              per-monitor participation mask
//   monitor_block     block flags from the monitors
//   clear             report acknowledge pulse
//   deadlock_irq      one-cycle pulse on entry to LATCHED
//   deadlock_valid    report valid while LATCHED
//   deadlock_idx      index of the first-blocking monitor
//   deadlock_vec      masked block vector captured at confirmation
//   block_cycles      saturating length of the current or last episode
//   state_dbg         registered state encoding
module hls_deadlock_report_ctrl
    import hls_deadlock_pkg::*;
#(
    parameter int N_MON          = 4,
    parameter int IDX_W          = 2,
    parameter int CNT_W          = DEFAULT_CNT_W,
    parameter int CONFIRM_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_MON-1:0] mask,
    input  logic [N_MON-1:0] monitor_block,
    input  logic             clear,
    output logic             deadlock_irq,
    output logic             deadlock_valid,
    output logic [IDX_W-1:0] deadlock_idx,
    output logic [N_MON-1:0] deadlock_vec,
    output logic [CNT_W-1:0] block_cycles,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] CONFIRM_M1 = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [31:0]      BC_MAX     = 32'((64'd1 << CNT_W) - 64'd1);

    logic [N_MON-1:0] act_s;
    logic             any_act_s;
    logic [IDX_W-1:0] first_idx_s;
    logic [CNT_W-1:0] bc_inc_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic             irq_q, irq_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_MON-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] bc_q, bc_d;

    assign act_s = monitor_block & mask;

    hls_deadlock_prio_enc #(
        .N     (N_MON),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (act_s),
        .idx_o   (first_idx_s),
        .found_o (any_act_s)
    );

    assign bc_inc_s = CNT_W'(sat_inc(32'(bc_q), BC_MAX));

    // Next-state, counter and report register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        irq_d   = 1'b0;
        valid_d = valid_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        bc_d    = bc_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && any_act_s) begin
                    state_d = ST_WATCH;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    bc_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                    cand_d  = first_idx_s;
                end else if (clear) begin
                    bc_d = {CNT_W{1'b0}};
                end else begin
                    bc_d = bc_q;
                end
            end
            ST_WATCH: begin
                // The episode length keeps growing on every blocked sample,
                // including the one on which WATCH is left.
                if (any_act_s) begin
                    bc_d = bc_inc_s;
                end else begin
                    bc_d = bc_q;
                end
                if (clear || !enable) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (!any_act_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CONFIRM_M1) begin
                    state_d = ST_LATCHED;
                    cnt_d   = {CNT_W{1'b0}};
                    vec_d   = act_s;
                    idx_d   = cand_q;
                    valid_d = 1'b1;
                    irq_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_LATCHED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    vec_d   = {N_MON{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    bc_d    = {CNT_W{1'b0}};
                end else if (any_act_s) begin
                    bc_d = bc_inc_s;
                end else begin
                    bc_d = bc_q;
                end
            end
            default: begin
                // Unreachable encoding: drop everything and restart cleanly.
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                cand_d  = {IDX_W{1'b0}};
                valid_d = 1'b0;
                idx_d   = {IDX_W{1'b0}};
                vec_d   = {N_MON{1'b0}};
                bc_d    = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and report registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            cand_q  <= {IDX_W{1'b0}};
            irq_q   <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            vec_q   <= {N_MON{1'b0}};
            bc_q    <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            irq_q   <= irq_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            bc_q    <= bc_d;
        end
    end

    assign deadlock_irq   = irq_q;
    assign deadlock_valid = valid_q;
    assign deadlock_idx   = idx_q;
    assign deadlock_vec   = vec_q;
    assign block_cycles   = bc_q;
    assign state_dbg      = state_q;

endmodule
